// File: rtl/serial_fir_ctrl_if.sv
// Sample-side and accumulator-side signals of the serial FIR sequencer.
// Handshake: a sample is transferred in any cycle where valid_i and ready_o
// are both high; valid_i while ready_o is low is a dropped sample, not a stall.
// state_o exposes the sequencer FSM state for observation.
interface serial_fir_ctrl_if;
  logic        valid_i;
  logic [11:0] data_i;
  logic        ready_o;
  logic        sample_we_o;
  logic [3:0]  sample_waddr_o;
  logic [11:0] sample_wdata_o;
  logic [3:0]  sample_raddr_o;
  logic [3:0]  coef_addr_o;
  logic        bypass_o;
  logic        capture_o;
  logic        dout_valid_o;
  logic        overrun_o;
  logic [7:0]  ovr_cnt_o;
  logic [1:0]  state_o;

  modport master (
    output valid_i, data_i,
    input  ready_o, sample_we_o, sample_waddr_o, sample_wdata_o, sample_raddr_o,
    input  coef_addr_o, bypass_o, capture_o, dout_valid_o, overrun_o, ovr_cnt_o,
    input  state_o
  );

  modport slave (
    input  valid_i, data_i,
    output ready_o, sample_we_o, sample_waddr_o, sample_wdata_o, sample_raddr_o,
    output coef_addr_o, bypass_o, capture_o, dout_valid_o, overrun_o, ovr_cnt_o,
    output state_o
  );
endinterface

// File: rtl/serial_fir_ctrl.sv
// Sequencer for a 16-tap serial FIR: clears the circular sample buffer after
// reset, accepts one sample per filter output, walks taps newest-first and
// times the accumulator bypass/capture strobes to the read+multiply latency.
// Optional macro SERIAL_FIR_OVR_CNT_EN adds a saturating dropped-sample count.
module serial_fir_ctrl #(
  parameter int RD_LAT   = 1,
  parameter int MULT_LAT = 3
) (
  input logic              clk_i,
  input logic              rst_i,
  serial_fir_ctrl_if.slave bus
);
  localparam int D = RD_LAT + MULT_LAT;

  typedef enum logic [1:0] {CLEAR = 2'd0, IDLE = 2'd1, RUN = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;    // clear address in CLEAR, tap index k in RUN
  logic [3:0]  wp_q, wp_d;
  logic [3:0]  base_q, base_d;
  logic        overrun_q;
  logic        ready, accept, drop;
  logic        issue_first, issue_last;
  logic        we;
  logic [3:0]  waddr, raddr, caddr;
  logic [11:0] wdata;
  logic [D-1:0] byp_sr_q, byp_sr_d;
  logic [D:0]   cap_sr_q, cap_sr_d;
  logic         dv_q;

  // Next-state: clear sweep, idle wait, tap walk; acceptance restarts the walk.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wp_d    = wp_q;
    base_d  = base_q;
    ready   = 1'b0;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = IDLE;
      end
      IDLE: ready = 1'b1;
      RUN: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          ready   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = CLEAR;
    endcase
    if (rst_i) ready = 1'b0;
    accept = ready && bus.valid_i;
    drop   = !ready && bus.valid_i && !rst_i;
    if (accept) begin
      state_d = RUN;
      cnt_d   = 4'd0;
      base_d  = wp_q;
      wp_d    = wp_q + 4'd1;
    end
  end

  // Buffer/ROM port drive; everything reads as zero while reset is held.
  always_comb begin
    we          = 1'b0;
    waddr       = 4'd0;
    wdata       = 12'd0;
    raddr       = 4'd0;
    caddr       = 4'd0;
    issue_first = 1'b0;
    issue_last  = 1'b0;
    if (!rst_i) begin
      if (state_q == CLEAR) begin
        we    = 1'b1;
        waddr = cnt_q;
      end else if (accept) begin
        we    = 1'b1;
        waddr = wp_q;
        wdata = bus.data_i;
      end
      if (state_q == RUN) begin
        raddr       = base_q - cnt_q;
        caddr       = cnt_q;
        issue_first = (cnt_q == 4'd0);
        issue_last  = (cnt_q == 4'd15);
      end
    end
  end

  // Strobe delay lines: first tap -> bypass after D, last tap -> capture after D+1.
  always_comb begin
    byp_sr_d    = byp_sr_q << 1;
    byp_sr_d[0] = issue_first;
    cap_sr_d    = cap_sr_q << 1;
    cap_sr_d[0] = issue_last;
  end

  // State, pointers, strobe pipeline and sticky overrun.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= CLEAR;
      cnt_q     <= 4'd0;
      wp_q      <= 4'd0;
      base_q    <= 4'd0;
      byp_sr_q  <= '0;
      cap_sr_q  <= '0;
      dv_q      <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wp_q     <= wp_d;
      base_q   <= base_d;
      byp_sr_q <= byp_sr_d;
      cap_sr_q <= cap_sr_d;
      dv_q     <= cap_sr_q[D];
      if (drop) overrun_q <= 1'b1;
    end
  end

`ifdef SERIAL_FIR_OVR_CNT_EN
  logic [7:0] ovr_cnt_q;

  // Saturating count of dropped samples.
  always_ff @(posedge clk_i) begin
    if (rst_i)                            ovr_cnt_q <= 8'd0;
    else if (drop && ovr_cnt_q != 8'hFF)  ovr_cnt_q <= ovr_cnt_q + 8'd1;
  end

  assign bus.ovr_cnt_o = rst_i ? 8'd0 : ovr_cnt_q;
`else
  assign bus.ovr_cnt_o = 8'd0;
`endif

  assign bus.ready_o        = ready;
  assign bus.sample_we_o    = we;
  assign bus.sample_waddr_o = waddr;
  assign bus.sample_wdata_o = wdata;
  assign bus.sample_raddr_o = raddr;
  assign bus.coef_addr_o    = caddr;
  assign bus.bypass_o       = byp_sr_q[D-1] && !rst_i;
  assign bus.capture_o      = cap_sr_q[D] && !rst_i;
  assign bus.dout_valid_o   = dv_q && !rst_i;
  assign bus.overrun_o      = overrun_q && !rst_i;
  assign bus.state_o        = state_q;
endmodule

// File: tb/tb_serial_fir_ctrl.sv
// Bench for serial_fir_ctrl: two instances (default latency D=4 and
// RD_LAT=2/MULT_LAT=0, D=2) share one stimulus stream. Expected behaviour is
// derived from acceptance times: ready when the previous sample is 16 cycles
// old, taps at t+1..t+16, strobe pulses scheduled into expected queues.
module tb_serial_fir_ctrl;
  localparam int DA = 4;
  localparam int DB = 2;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_fir_ctrl_if bus_a ();
  serial_fir_ctrl_if bus_b ();

  serial_fir_ctrl #(.RD_LAT(1), .MULT_LAT(3)) dut_a (.clk_i(clk), .rst_i(rst), .bus(bus_a));
  serial_fir_ctrl #(.RD_LAT(2), .MULT_LAT(0)) dut_b (.clk_i(clk), .rst_i(rst), .bus(bus_b));

  // Reference model
  int n_err = 0;
  int n_chk = 0;
  int cyc, free_at, t_last, m_wp, m_base, drops;
  bit m_ovr;
  logic [31:0] exp_byp_a_q[$], exp_cap_a_q[$], exp_dv_a_q[$];
  logic [31:0] exp_byp_b_q[$], exp_cap_b_q[$], exp_dv_b_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    free_at = 16;
    t_last  = -1000;
    m_wp    = 0;
    m_base  = 0;
    drops   = 0;
    m_ovr   = 1'b0;
    exp_byp_a_q.delete(); exp_cap_a_q.delete(); exp_dv_a_q.delete();
    exp_byp_b_q.delete(); exp_cap_b_q.delete(); exp_dv_b_q.delete();
  endtask

  // Driver: one clock cycle of stimulus, checked at the falling edge.
  task automatic step(input logic v, input logic [11:0] d);
    bit rdy, acc, e;
    int k, exp_cnt;
    bus_a.valid_i = v; bus_a.data_i = d;
    bus_b.valid_i = v; bus_b.data_i = d;
    @(negedge clk);
    if (rst) begin
      chk("rst_ready", bus_a.ready_o, 0);
      chk("rst_we", bus_a.sample_we_o, 0);
      chk("rst_waddr", bus_a.sample_waddr_o, 0);
      chk("rst_wdata", bus_a.sample_wdata_o, 0);
      chk("rst_raddr", bus_a.sample_raddr_o, 0);
      chk("rst_coef", bus_a.coef_addr_o, 0);
      chk("rst_bypass", bus_a.bypass_o, 0);
      chk("rst_capture", bus_a.capture_o, 0);
      chk("rst_dvalid", bus_a.dout_valid_o, 0);
      chk("rst_overrun", bus_a.overrun_o, 0);
      chk("rst_ovr_cnt", bus_a.ovr_cnt_o, 0);
      chk("rst_b_bypass", bus_b.bypass_o, 0);
      chk("rst_b_dvalid", bus_b.dout_valid_o, 0);
      model_reset();
      cyc = -1;
    end else begin
      rdy = (cyc >= free_at);
      acc = v && rdy;
      chk("ready", bus_a.ready_o, rdy);
      chk("b_ready", bus_b.ready_o, rdy);
      chk("we", bus_a.sample_we_o, (cyc < 16) || acc);
      if (cyc < 16) begin
        chk("clr_waddr", bus_a.sample_waddr_o, cyc & 15);
        chk("clr_wdata", bus_a.sample_wdata_o, 0);
      end else if (acc) begin
        chk("waddr", bus_a.sample_waddr_o, m_wp);
        chk("wdata", bus_a.sample_wdata_o, d);
      end
      if (cyc >= t_last + 1 && cyc <= t_last + 16) begin
        k = cyc - t_last - 1;
        chk("coef_addr", bus_a.coef_addr_o, k);
        chk("raddr", bus_a.sample_raddr_o, (m_base - k) & 15);
      end
      e = (exp_byp_a_q.size() > 0 && exp_byp_a_q[0] == cyc);
      if (e) void'(exp_byp_a_q.pop_front());
      chk("bypass", bus_a.bypass_o, e);
      e = (exp_cap_a_q.size() > 0 && exp_cap_a_q[0] == cyc);
      if (e) void'(exp_cap_a_q.pop_front());
      chk("capture", bus_a.capture_o, e);
      e = (exp_dv_a_q.size() > 0 && exp_dv_a_q[0] == cyc);
      if (e) void'(exp_dv_a_q.pop_front());
      chk("dout_valid", bus_a.dout_valid_o, e);
      e = (exp_byp_b_q.size() > 0 && exp_byp_b_q[0] == cyc);
      if (e) void'(exp_byp_b_q.pop_front());
      chk("b_bypass", bus_b.bypass_o, e);
      e = (exp_cap_b_q.size() > 0 && exp_cap_b_q[0] == cyc);
      if (e) void'(exp_cap_b_q.pop_front());
      chk("b_capture", bus_b.capture_o, e);
      e = (exp_dv_b_q.size() > 0 && exp_dv_b_q[0] == cyc);
      if (e) void'(exp_dv_b_q.pop_front());
      chk("b_dout_valid", bus_b.dout_valid_o, e);
      chk("overrun", bus_a.overrun_o, m_ovr);
`ifdef SERIAL_FIR_OVR_CNT_EN
      exp_cnt = (drops > 255) ? 255 : drops;
`else
      exp_cnt = 0;
`endif
      chk("ovr_cnt", bus_a.ovr_cnt_o, exp_cnt);
      if (v && !rdy) begin
        m_ovr = 1'b1;
        drops++;
      end
      if (acc) begin
        m_base  = m_wp;
        m_wp    = (m_wp + 1) % 16;
        t_last  = cyc;
        free_at = cyc + 16;
        exp_byp_a_q.push_back(cyc + 1 + DA);
        exp_cap_a_q.push_back(cyc + 17 + DA);
        exp_dv_a_q.push_back(cyc + 18 + DA);
        exp_byp_b_q.push_back(cyc + 1 + DB);
        exp_cap_b_q.push_back(cyc + 17 + DB);
        exp_dv_b_q.push_back(cyc + 18 + DB);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Directed sequence with randomized data and valid patterns
  initial begin
    model_reset();
    cyc = 0;
    bus_a.valid_i = 1'b0; bus_a.data_i = 12'd0;
    bus_b.valid_i = 1'b0; bus_b.data_i = 12'd0;
    @(posedge clk);
    #1;

    // reset values, then the 16-cycle clear sweep and idle
    rst = 1'b1;
    repeat (3) step(1'b0, 12'd0);
    rst = 1'b0;
    repeat (20) step(1'b0, 12'd0);

    // single sample 0x123
    step(1'b1, 12'h123);
    repeat (30) step(1'b0, 12'd0);

    // 20 back-to-back samples aligned to the last tap
    for (int i = 0; i < 20; i++) begin
      while (cyc < free_at) step(1'b0, 12'd0);
      step(1'b1, 12'($urandom));
    end
    repeat (30) step(1'b0, 12'd0);

    // valid at tap 5 is dropped
    step(1'b1, 12'($urandom));
    repeat (5) step(1'b0, 12'd0);
    step(1'b1, 12'($urandom));
    repeat (12) step(1'b0, 12'd0);

    // continuous valid: ~300 drops, count saturates
    repeat (320) step(1'b1, 12'($urandom));
    repeat (25) step(1'b0, 12'd0);

    // random valid pattern
    repeat (200) step(1'($urandom_range(0, 3) == 0), 12'($urandom));
    repeat (25) step(1'b0, 12'd0);

    // reset at tap 8 cancels strobes in flight, clear restarts
    step(1'b1, 12'($urandom));
    repeat (8) step(1'b0, 12'd0);
    rst = 1'b1;
    repeat (2) step(1'b0, 12'd0);
    rst = 1'b0;
    repeat (3) step(1'b0, 12'd0);
    step(1'b1, 12'($urandom));
    repeat (40) step(1'b0, 12'd0);
    step(1'b1, 12'($urandom));
    repeat (30) step(1'b0, 12'd0);

    chk("pending_strobes",
        exp_byp_a_q.size() + exp_cap_a_q.size() + exp_dv_a_q.size() +
        exp_byp_b_q.size() + exp_cap_b_q.size() + exp_dv_b_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
